// File: rtl/dsp_logic_pkg.sv
// dsp_logic_pkg: op codes and per-bit logic helpers shared by the logic pipe
package dsp_logic_pkg;
  typedef enum logic [2:0] {
    OP_XOR, OP_AND, OP_OR, OP_XNOR, OP_NAND, OP_NOR, OP_ANDN, OP_PASS
  } op_e;

  function automatic logic logic_op(input logic a, input logic b, input op_e op);
    case (op)
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XNOR: return ~(a ^ b);
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_ANDN: return a & ~b;
      default: return a;
    endcase
  endfunction

  function automatic logic acc_legal(input op_e op);
    return op inside {OP_XOR, OP_AND, OP_OR};
  endfunction
endpackage

// File: rtl/dsp_logic_stage.sv
// dsp_logic_stage: one valid/ready register slice carrying an opaque payload
module dsp_logic_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce_i,
  input  logic         ready_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ce_i && ready_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/dsp_logic_pipe.sv
// dsp_logic_pipe: flow-controlled bitwise logic pipeline with reduction accumulator
module dsp_logic_pipe
  import dsp_logic_pkg::*;
#(
  parameter int WIDTH   = 48,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       opsel_i,
  input  logic             acc_en_i,
  input  logic             acc_first_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);
  localparam int PW = WIDTH + 5;

  if (WIDTH < 1 || WIDTH > 96 || LATENCY < 1 || LATENCY > 4) begin : g_bad_param
    $error("dsp_logic_pipe: illegal WIDTH=%0d or LATENCY=%0d", WIDTH, LATENCY);
  end

  logic [WIDTH-1:0]   r;
  logic               s_v [LATENCY];
  logic [PW-1:0]      s_d [LATENCY];
  logic [LATENCY-1:0] vall, rdy;

  always_comb
    for (int i = 0; i < WIDTH; i++) r[i] = logic_op(a_i[i], b_i[i], op_e'(opsel_i));

  assign s_v[0]     = in_valid_i;
  assign s_d[0]     = {r, opsel_i, acc_en_i, acc_first_i};
  assign in_ready_o = rst_n & ce_i & rdy[0];
  assign busy_o     = |vall;

  // Ready is derived from the valid bits directly, so no comb chain runs stage to stage
  for (genvar k = 0; k < LATENCY; k++) begin : g_rdy
    assign rdy[k] = out_ready_i | ~&vall[LATENCY-1:k];
  end

  for (genvar j = 0; j < LATENCY - 1; j++) begin : g_stage
    dsp_logic_stage #(.W(PW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .ce_i    (ce_i),
      .ready_i (rdy[j]),
      .valid_i (s_v[j]),
      .data_i  (s_d[j]),
      .valid_o (s_v[j+1]),
      .data_o  (s_d[j+1])
    );
    assign vall[j] = s_v[j+1];
  end

  logic [WIDTH-1:0] lr, comb, acc_q, acc_d, res_q, res_d;
  logic [2:0]       lop;
  logic             len, lfirst, eff, val_q;

  assign {lr, lop, len, lfirst} = s_d[LATENCY-1];

  always_comb begin
    eff = len & acc_legal(op_e'(lop));
    for (int i = 0; i < WIDTH; i++) comb[i] = logic_op(acc_q[i], lr[i], op_e'(lop));
    acc_d = !eff ? acc_q : lfirst ? lr : comb;
    res_d = eff ? acc_d : lr;
  end

  // Accumulator only moves when a beat enters this stage: one update point per beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      val_q <= 1'b0;
      acc_q <= '0;
      res_q <= '0;
    end else if (ce_i && rdy[LATENCY-1]) begin
      val_q <= s_v[LATENCY-1];
      if (s_v[LATENCY-1]) begin
        acc_q <= acc_d;
        res_q <= res_d;
      end
    end

  assign vall[LATENCY-1] = val_q;
  assign out_valid_o     = val_q;
  assign result_o        = res_q;
endmodule
